// File: rtl/panel_pkg.sv
// Shared front-panel definitions: mode encoding, entry patterns, switch indices.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package panel_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_MANUAL = 2'd3
    } mode_e;

    localparam logic [3:0] PAT_OFF    = 4'b0000;
    localparam logic [3:0] PAT_CHASE  = 4'b0001;
    localparam logic [3:0] PAT_BLINK  = 4'b1111;
    localparam logic [3:0] PAT_MANUAL = 4'b0001;

    localparam int NUM_SW   = 4;
    localparam int SW_MODE  = 0;   // SW1: mode advance
    localparam int SW_SLOW  = 1;   // SW2: half-speed toggle
    localparam int SW_PAUSE = 2;   // SW3: pause toggle
    localparam int SW_STEP  = 3;   // SW4: manual step / pattern reload

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_OFF:    return MODE_CHASE;
            MODE_CHASE:  return MODE_BLINK;
            MODE_BLINK:  return MODE_MANUAL;
            default:     return MODE_OFF;
        endcase
    endfunction

    function automatic logic [3:0] entry_pattern(input mode_e m);
        case (m)
            MODE_OFF:    return PAT_OFF;
            MODE_CHASE:  return PAT_CHASE;
            MODE_BLINK:  return PAT_BLINK;
            default:     return PAT_MANUAL;
        endcase
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

endpackage

// File: rtl/switch_release_detect.sv
// Synchronizes, debounces one raw switch and pulses on each debounced release (1->0).
// Latency: 2 sync flops + DEBOUNCE_LIMIT stable clocks; o_Release pulses with the o_Level fall.
// Backpressure: none; o_Release is a single-cycle pulse the consumer must capture.
// Ports: i_Clk, i_Rst (sync, active-high), i_Switch (async raw), o_Level (debounced), o_Release (pulse).
module switch_release_detect #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Release
);

    localparam int CW = (DEBOUNCE_LIMIT < 2) ? 1 : $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            stable_cnt <= '0;
            o_Level    <= 1'b0;
            o_Release  <= 1'b0;
        end else begin
            sync_1    <= i_Switch;
            sync_2    <= sync_1;
            o_Release <= 1'b0;
            // Count consecutive cycles the synchronized input disagrees with
            // the debounced level; any agreement restarts the count.
            if (sync_2 != o_Level) begin
                if (stable_cnt == CNT_LAST) begin
                    o_Level    <= sync_2;
                    stable_cnt <= '0;
                    // Old level 1 means this flip is a release.
                    o_Release  <= o_Level;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_led_controller.sv
// Front-panel controller: 4 debounced switch releases drive a mode FSM and a 4-LED pattern.
// Latency: release pulse in cycle N -> pending N+1 -> command visible on outputs N+2.
// Backpressure: one command per cycle, fixed priority SW1>SW2>SW3>SW4; others held pending.
// Ports: i_Clk, i_Rst (sync, active-high), i_Switch_1..4 (raw), o_LED_1..4, o_Mode[1:0], o_Paused, o_Slow.
module switch_led_controller #(
    parameter int CLKS_PER_TICK  = 2500000,
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode,
    output logic       o_Paused,
    output logic       o_Slow
);

    import panel_pkg::*;

    localparam int CW = $clog2(2 * CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST_NORMAL = CW'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] LAST_SLOW   = CW'(2 * CLKS_PER_TICK - 1);

    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] sw_level;
    logic [NUM_SW-1:0] sw_release;
    logic [NUM_SW-1:0] pend_set;
    logic [NUM_SW-1:0] pending;
    logic [NUM_SW-1:0] grant;

    mode_e             mode;
    logic [3:0]        pattern;
    logic              paused;
    logic              slow;
    logic [CW-1:0]     tick_cnt;
    logic [CW-1:0]     tick_last;
    logic              running;

    assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        switch_release_detect #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_detect (
            .i_Clk     (i_Clk),
            .i_Rst     (i_Rst),
            .i_Switch  (sw_raw[g]),
            .o_Level   (sw_level[g]),
            .o_Release (sw_release[g])
        );
    end

    // A release pulse always coincides with the level reading released;
    // qualifying on it keeps stray pulses from ever becoming commands.
    assign pend_set = sw_release & ~sw_level;

    // Lowest set bit wins: bit 0 is SW1, the highest priority.
    assign grant = pending & (~pending + 4'd1);

    assign running   = ((mode == MODE_CHASE) || (mode == MODE_BLINK)) && !paused;
    assign tick_last = slow ? LAST_SLOW : LAST_NORMAL;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode     <= MODE_OFF;
            pattern  <= PAT_OFF;
            pending  <= '0;
            paused   <= 1'b0;
            slow     <= 1'b0;
            tick_cnt <= '0;
        end else begin
            // Set after clear: a new release on the granted switch stays pending.
            pending <= (pending & ~grant) | pend_set;

            // A command cycle never advances the counter, so a tick due in
            // the same cycle is dropped.
            if (grant[SW_MODE]) begin
                mode     <= next_mode(mode);
                pattern  <= entry_pattern(next_mode(mode));
                paused   <= 1'b0;
                tick_cnt <= '0;
            end else if (grant[SW_SLOW]) begin
                slow     <= ~slow;
                tick_cnt <= '0;
            end else if (grant[SW_PAUSE]) begin
                if ((mode == MODE_CHASE) || (mode == MODE_BLINK)) begin
                    paused <= ~paused;
                end
            end else if (grant[SW_STEP]) begin
                if (mode == MODE_MANUAL) begin
                    pattern <= rotl4(pattern);
                end else begin
                    pattern  <= entry_pattern(mode);
                    tick_cnt <= '0;
                end
            end else if (running) begin
                if (tick_cnt == tick_last) begin
                    tick_cnt <= '0;
                    pattern  <= (mode == MODE_CHASE) ? rotl4(pattern) : ~pattern;
                end else begin
                    tick_cnt <= tick_cnt + CW'(1);
                end
            end
        end
    end

    assign o_LED_1  = pattern[0];
    assign o_LED_2  = pattern[1];
    assign o_LED_3  = pattern[2];
    assign o_LED_4  = pattern[3];
    assign o_Mode   = mode;
    assign o_Paused = paused;
    assign o_Slow   = slow;

endmodule

// File: tb/tb_switch_led_controller.sv
// Self-checking bench for switch_led_controller with a behavioural panel model.
// Latency: model steps once per rising edge; outputs compared on the falling edge.
// Backpressure: n/a.
module tb_switch_led_controller;

    localparam int TICK = 4;
    localparam int DEB  = 3;
    localparam int HL   = 2 + DEB;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       led_1, led_2, led_3, led_4;
    logic [1:0] mode_out;
    logic       paused_out;
    logic       slow_out;
    logic [7:0] dut_vec;

    int tests = 0;
    int fails = 0;

    switch_led_controller #(
        .CLKS_PER_TICK  (TICK),
        .DEBOUNCE_LIMIT (DEB)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch_1 (sw[0]),
        .i_Switch_2 (sw[1]),
        .i_Switch_3 (sw[2]),
        .i_Switch_4 (sw[3]),
        .o_LED_1    (led_1),
        .o_LED_2    (led_2),
        .o_LED_3    (led_3),
        .o_LED_4    (led_4),
        .o_Mode     (mode_out),
        .o_Paused   (paused_out),
        .o_Slow     (slow_out)
    );

    assign dut_vec = {mode_out, paused_out, slow_out, led_4, led_3, led_2, led_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_mode = 0;
    int          m_pat  = 0;
    int          m_cnt  = 0;
    bit          m_paused = 0;
    bit          m_slow   = 0;
    bit [3:0]    m_pend = '0;
    bit [3:0]    m_rel  = '0;
    bit [3:0]    m_lvl  = '0;
    bit [HL-1:0] m_hist [4];

    function automatic int entry(input int m);
        case (m)
            0:       return 0;
            1:       return 1;
            2:       return 15;
            default: return 1;
        endcase
    endfunction

    function automatic int rot(input int p);
        return ((p * 2) + (p / 8)) % 16;
    endfunction

    function automatic logic [7:0] model_vec();
        return {2'(m_mode), m_paused, m_slow, 4'(m_pat)};
    endfunction

    task automatic model_step();
        int  g;
        bit  flip;
        bit [3:0] new_rel;
        if (rst) begin
            m_mode = 0; m_pat = 0; m_cnt = 0; m_paused = 0; m_slow = 0;
            m_pend = '0; m_rel = '0; m_lvl = '0;
            for (int k = 0; k < 4; k++) m_hist[k] = '0;
            return;
        end
        g = -1;
        for (int k = 0; k < 4; k++) if (g < 0 && m_pend[k]) g = k;
        case (g)
            0: begin
                m_mode = (m_mode + 1) % 4; m_paused = 0; m_cnt = 0; m_pat = entry(m_mode);
            end
            1: begin m_slow = !m_slow; m_cnt = 0; end
            2: if (m_mode == 1 || m_mode == 2) m_paused = !m_paused;
            3: begin
                if (m_mode == 3) m_pat = rot(m_pat);
                else begin m_pat = entry(m_mode); m_cnt = 0; end
            end
            default: begin
                if ((m_mode == 1 || m_mode == 2) && !m_paused) begin
                    m_cnt = (m_cnt + 1) % (m_slow ? 2 * TICK : TICK);
                    if (m_cnt == 0) m_pat = (m_mode == 1) ? rot(m_pat) : (m_pat ^ 15);
                end
            end
        endcase
        if (g >= 0) m_pend[g] = 1'b0;
        m_pend = m_pend | m_rel;
        // The debounced level flips once the last DEB synchronized samples
        // (raw delayed by two clocks) all disagree with it.
        for (int k = 0; k < 4; k++) begin
            m_hist[k] = {m_hist[k][HL-2:0], sw[k]};
            flip = 1'b1;
            for (int j = 2; j < 2 + DEB; j++) if (m_hist[k][j] == m_lvl[k]) flip = 1'b0;
            new_rel[k] = flip && m_lvl[k];
            if (flip) m_lvl[k] = ~m_lvl[k];
        end
        m_rel = new_rel;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic wait_rel(input logic [3:0] mask);
        int n;
        n = 0;
        while (((m_rel & mask) != mask) && n < 20) begin step(); n++; end
        if ((m_rel & mask) != mask) begin
            tests++; fails++;
            $display("FAIL release_timeout: mask %b not released after %0d cycles", mask, n);
        end
    endtask

    // Press, hold long enough to debounce, release; returns in cycle N.
    task automatic do_release(input int k);
        sw[k] = 1'b1;
        repeat (8) step();
        sw[k] = 1'b0;
        wait_rel(4'(1 << k));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        sw  = 4'b0000;
        repeat (3) step();
        tests++;
        if (dut_vec !== 8'h00) begin fails++; $display("FAIL reset_state: got %b expected %b", dut_vec, 8'h00); end
        rst = 1'b0;
        repeat (10) step();
        tests++;
        if (dut_vec !== 8'h00 || dut_vec !== model_vec())
            begin fails++; $display("FAIL reset_idle: got %b expected %b", dut_vec, 8'h00); end
    endtask

    task automatic test_chase();
        int edges;
        apply_reset();
        sw[0] = 1'b1;
        repeat (8) step();
        sw[0] = 1'b0;
        edges = 0;
        while (mode_out == 2'd0 && edges < 20) begin step(); edges++; end
        tests++;
        if (edges !== 7) begin fails++; $display("FAIL sw1_latency: got %0d clocks expected 7", edges); end
        tests++;
        if (dut_vec !== 8'b01_0_0_0001) begin fails++; $display("FAIL chase_entry: got %b expected %b", dut_vec, 8'b01000001); end
        repeat (4) step();
        tests++;
        if (dut_vec !== 8'b01_0_0_0010 || dut_vec !== model_vec())
            begin fails++; $display("FAIL chase_step: got %b expected %b", dut_vec, 8'b01000010); end
        repeat (12) step();
        tests++;
        if (dut_vec !== 8'b01_0_0_0001 || dut_vec !== model_vec())
            begin fails++; $display("FAIL chase_wrap: got %b expected %b", dut_vec, 8'b01000001); end
    endtask

    task automatic test_blink_slow();
        logic [3:0] l;
        apply_reset();
        do_release(0); step(); step();
        do_release(0); step();
        tests++;
        if (mode_out !== 2'd1) begin fails++; $display("FAIL blink_n1: mode %0d expected 1", mode_out); end
        step();
        tests++;
        if (dut_vec !== 8'b10_0_0_1111) begin fails++; $display("FAIL blink_entry: got %b expected %b", dut_vec, 8'b10001111); end
        repeat (4) step();
        tests++;
        if (dut_vec !== 8'b10_0_0_0000) begin fails++; $display("FAIL blink_toggle: got %b expected %b", dut_vec, 8'b10000000); end
        do_release(1); step();
        tests++;
        if (slow_out !== 1'b0) begin fails++; $display("FAIL slow_n1: got %b expected 0", slow_out); end
        step();
        tests++;
        if (slow_out !== 1'b1 || dut_vec !== model_vec())
            begin fails++; $display("FAIL slow_set: got %b expected %b", dut_vec, model_vec()); end
        l = dut_vec[3:0];
        repeat (7) step();
        tests++;
        if (dut_vec[3:0] !== l) begin fails++; $display("FAIL slow_hold7: got %b expected %b", dut_vec[3:0], l); end
        step();
        tests++;
        if (dut_vec[3:0] !== ~l || dut_vec !== model_vec())
            begin fails++; $display("FAIL slow_toggle8: got %b expected %b", dut_vec[3:0], ~l); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        sw = 4'b1101;
        repeat (8) step();
        sw = 4'b0000;
        wait_rel(4'b1101);
        step();
        tests++;
        if (dut_vec !== 8'h00) begin fails++; $display("FAIL simul_n1: got %b expected %b", dut_vec, 8'h00); end
        step();
        tests++;
        if (dut_vec !== 8'b01_0_0_0001) begin fails++; $display("FAIL simul_n2: got %b expected %b", dut_vec, 8'b01000001); end
        step();
        tests++;
        if (dut_vec !== 8'b01_1_0_0001) begin fails++; $display("FAIL simul_n3: got %b expected %b", dut_vec, 8'b01100001); end
        step();
        tests++;
        if (dut_vec !== 8'b01_1_0_0001 || dut_vec !== model_vec())
            begin fails++; $display("FAIL simul_n4: got %b expected %b", dut_vec, 8'b01100001); end
        repeat (20) step();
        tests++;
        if (dut_vec !== 8'b01_1_0_0001) begin fails++; $display("FAIL simul_frozen: got %b expected %b", dut_vec, 8'b01100001); end
    endtask

    task automatic test_pause();
        logic [3:0] l;
        int n;
        apply_reset();
        do_release(0); step(); step();
        sw[2] = 1'b1;
        repeat (8) step();
        n = 0;
        while (m_cnt != 0 && n < 8) begin step(); n++; end
        // Six counting edges after the drop, then the command edge sees count 2.
        sw[2] = 1'b0;
        repeat (7) step();
        tests++;
        if (paused_out !== 1'b1 || dut_vec !== model_vec())
            begin fails++; $display("FAIL pause_set: got %b expected %b", dut_vec, model_vec()); end
        l = dut_vec[3:0];
        repeat (20) step();
        tests++;
        if (dut_vec[3:0] !== l || paused_out !== 1'b1)
            begin fails++; $display("FAIL pause_frozen: got %b expected %b", dut_vec[3:0], l); end
        sw[2] = 1'b1;
        repeat (8) step();
        sw[2] = 1'b0;
        repeat (7) step();
        tests++;
        if (paused_out !== 1'b0 || dut_vec[3:0] !== l)
            begin fails++; $display("FAIL pause_resume: got %b expected leds %b unpaused", dut_vec, l); end
        step();
        tests++;
        if (dut_vec[3:0] !== l) begin fails++; $display("FAIL resume_plus1: got %b expected %b", dut_vec[3:0], l); end
        step();
        tests++;
        if (dut_vec[3:0] !== {l[2:0], l[3]} || dut_vec !== model_vec())
            begin fails++; $display("FAIL resume_plus2: got %b expected %b", dut_vec[3:0], {l[2:0], l[3]}); end
    endtask

    task automatic test_manual();
        logic [3:0] exp;
        apply_reset();
        for (int i = 0; i < 3; i++) begin do_release(0); step(); step(); end
        tests++;
        if (dut_vec !== 8'b11_0_0_0001) begin fails++; $display("FAIL manual_entry: got %b expected %b", dut_vec, 8'b11000001); end
        for (int i = 0; i < 3; i++) begin
            do_release(3); step(); step();
            exp = 4'(1 << (i + 1));
            tests++;
            if (dut_vec[3:0] !== exp || dut_vec !== model_vec())
                begin fails++; $display("FAIL manual_step%0d: got %b expected %b", i, dut_vec[3:0], exp); end
        end
        sw[0] = 1'b1;
        repeat (8) step();
        sw[0] = 1'b0;
        repeat (2) step();
        sw[0] = 1'b1;
        repeat (12) step();
        tests++;
        if (dut_vec !== 8'b11_0_0_1000 || dut_vec !== model_vec())
            begin fails++; $display("FAIL glitch_ignored: got %b expected %b", dut_vec, 8'b11001000); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_release(0); step(); step();
        do_release(1);
        step();
        rst = 1'b1;
        step();
        tests++;
        if (dut_vec !== 8'h00) begin fails++; $display("FAIL reset_mid: got %b expected %b", dut_vec, 8'h00); end
        rst = 1'b0;
        repeat (20) step();
        tests++;
        if (dut_vec !== 8'h00 || dut_vec !== model_vec())
            begin fails++; $display("FAIL reset_discard: got %b expected %b", dut_vec, 8'h00); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) if ($urandom_range(0, 9) == 0) sw[k] = ~sw[k];
            rst = ($urandom_range(0, 499) == 0);
            step();
            tests++;
            if (dut_vec !== model_vec())
                begin fails++; $display("FAIL random_c%0d: got %b expected %b", c, dut_vec, model_vec()); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'b0000;
        for (int k = 0; k < 4; k++) m_hist[k] = '0;
        test_reset();
        test_chase();
        test_blink_slow();
        test_simultaneous();
        test_pause();
        test_manual();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
